// File: rtl/boot_pkg.sv
// boot_pkg: shared types and constants for the cartridge boot loader.
package boot_pkg;
    typedef enum logic [2:0] {S_HDR, S_CLAMP, S_WORD, S_WRITE, S_DONE} boot_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LATCH, R_LOW, R_SAMPLE} rd_state_t;
    localparam int INSTR_W = 32;
    localparam int HDR_LEN = 2;
endpackage

// File: rtl/rom_byte_reader.sv
// rom_byte_reader: fetches one byte over the multiplexed ROM address port
// (latch high byte, hold low byte, sample).
module rom_byte_reader
    import boot_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int LATCH_PULSE = 2,
    parameter int DATA_WAIT   = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              req_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [7:0]        rom_data_in,
    output logic              ready_out,
    output logic              valid_out,
    output logic [7:0]        byte_out,
    output logic [7:0]        rom_addr_out,
    output logic              rom_latch_out
);
    localparam int CMAX = LATCH_PULSE > DATA_WAIT ? LATCH_PULSE : DATA_WAIT;
    localparam int CW   = $clog2(CMAX + 1);

    rd_state_t         state, next_state;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] addr, next_addr;

    // The SAMPLE cycle also accepts the next request so bytes stream back to back.
    assign ready_out = state == R_IDLE || state == R_SAMPLE;
    assign valid_out = state == R_SAMPLE;
    assign byte_out  = rom_data_in;

    always_comb begin
        next_addr  = (ready_out && req_in) ? addr_in : addr;
        next_state = state;
        case (state)
            R_IDLE, R_SAMPLE: next_state = req_in ? R_LATCH : R_IDLE;
            R_LATCH:          next_state = cnt == CW'(LATCH_PULSE - 1) ? R_LOW : R_LATCH;
            R_LOW:            next_state = cnt == CW'(DATA_WAIT - 1) ? R_SAMPLE : R_LOW;
            default:          next_state = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state         <= R_IDLE;
            cnt           <= '0;
            addr          <= '0;
            rom_addr_out  <= '0;
            rom_latch_out <= 1'b0;
        end else begin
            state         <= next_state;
            cnt           <= next_state == state ? cnt + 1'b1 : '0;
            addr          <= next_addr;
            rom_latch_out <= next_state == R_LATCH;
            rom_addr_out  <= next_state == R_LATCH ? 8'(next_addr >> 8) : next_addr[7:0];
        end
    end
endmodule

// File: rtl/cart_boot_loader.sv
// cart_boot_loader: copies a length-prefixed instruction image from cartridge ROM
// into program memory, holding the system in reset until the copy completes.
module cart_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WORD_ADDR_W = 12,
    parameter int LATCH_PULSE = 2,
    parameter int DATA_WAIT   = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    output logic [7:0]             rom_addr_out,
    output logic                   rom_latch_out,
    input  logic [7:0]             rom_data_in,
    output logic                   pm_we_out,
    output logic [WORD_ADDR_W-1:0] pm_addr_out,
    output logic [INSTR_W-1:0]     pm_data_out,
    output logic                   sys_rst_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   err_out
);
    localparam int          KW  = WORD_ADDR_W + 1;
    localparam logic [16:0] CAP = 17'(1) << WORD_ADDR_W;

    boot_state_t        state, next_state;
    logic [ADDR_W-1:0]  rom_a;
    logic [15:0]        hdr;
    logic [KW-1:0]      n, k, k_inc;
    logic [2:0]         rq;
    logic [1:0]         rc;
    logic [INSTR_W-1:0] sh;
    logic               req, ready, valid, clamp;
    logic [7:0]         byte_v;

    assign k_inc = k + 1'b1;
    assign clamp = {1'b0, hdr} > CAP;

    rom_byte_reader #(
        .ADDR_W(ADDR_W), .LATCH_PULSE(LATCH_PULSE), .DATA_WAIT(DATA_WAIT)
    ) u_reader (
        .clk_in(clk_in), .rst_in(rst_in), .req_in(req), .addr_in(rom_a),
        .rom_data_in(rom_data_in), .ready_out(ready), .valid_out(valid),
        .byte_out(byte_v), .rom_addr_out(rom_addr_out), .rom_latch_out(rom_latch_out)
    );

    // req is raised one cycle ahead so the reader chains the next byte without a gap.
    always_comb begin
        next_state = state;
        req        = 1'b0;
        case (state)
            S_HDR: begin
                req = rom_a < ADDR_W'(HDR_LEN);
                if (valid && rc == 2'd1) next_state = S_CLAMP;
            end
            S_CLAMP: begin
                req        = hdr != '0;
                next_state = hdr == '0 ? S_DONE : S_WORD;
            end
            S_WORD: begin
                req = rq < 3'd4;
                if (valid && rc == 2'd3) next_state = S_WRITE;
            end
            S_WRITE: begin
                req        = k_inc < n;
                next_state = k_inc < n ? S_WORD : S_DONE;
            end
            S_DONE:  next_state = start_in ? S_HDR : S_DONE;
            default: next_state = S_HDR;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= S_HDR;
            rom_a       <= '0;
            hdr         <= '0;
            n           <= '0;
            k           <= '0;
            rq          <= '0;
            rc          <= '0;
            sh          <= '0;
            pm_we_out   <= 1'b0;
            pm_addr_out <= '0;
            pm_data_out <= '0;
            sys_rst_out <= 1'b1;
            busy_out    <= 1'b1;
            done_out    <= 1'b0;
            err_out     <= 1'b0;
        end else begin
            state       <= next_state;
            sys_rst_out <= next_state != S_DONE;
            busy_out    <= next_state != S_DONE;
            done_out    <= next_state == S_DONE;
            pm_we_out   <= next_state == S_WRITE;
            if (state == S_DONE && start_in) begin
                rom_a   <= '0;
                k       <= '0;
                err_out <= 1'b0;
            end else if (req && ready) begin
                rom_a <= rom_a + 1'b1;
                rq    <= state == S_WORD ? rq + 3'd1 : 3'd1;
            end
            if (valid) begin
                rc <= rc + 2'd1;
                if (state == S_HDR) hdr <= {byte_v, hdr[15:8]};
                else sh <= {byte_v, sh[INSTR_W-1:8]};
            end
            if (state == S_CLAMP) begin
                rc      <= '0;
                n       <= clamp ? KW'(CAP) : KW'(hdr);
                err_out <= clamp;
            end
            if (next_state == S_WRITE) begin
                pm_addr_out <= k[WORD_ADDR_W-1:0];
                pm_data_out <= {byte_v, sh[INSTR_W-1:8]};
            end
            if (state == S_WRITE) k <= k_inc;
        end
    end
endmodule
